// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: FSM state encodings,
// address width default and the NOP word that flushed stages are loaded with.
package pipe_ctrl_pkg;

  localparam int unsigned AddrWidthDefault = 32;

  // RISC-V canonical NOP (addi x0, x0, 0); flushed IF/ID and ID/EX stages load this.
  localparam logic [31:0] NopInstr = 32'h0000_0013;

  typedef enum logic [1:0] {
    StRun    = 2'b00,
    StMdWait = 2'b01,
    StDrain  = 2'b10,
    StHalted = 2'b11
  } state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Event/control bundle between the pipeline and pipe_ctrl. With PIPE_CTRL_PERF_EN
// defined the bundle also carries the stall/flush performance counters.
interface pipe_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = pipe_ctrl_pkg::AddrWidthDefault
) ();

  logic                  jump_req_i;
  logic [ADDR_WIDTH-1:0] jump_addr_i;
  logic                  ld_use_i;
  logic                  md_start_i;
  logic                  md_done_i;
  logic                  halt_req_i;
  logic                  resume_i;

  logic                  pc_hold_o;
  logic                  pc_redirect_o;
  logic [ADDR_WIDTH-1:0] pc_redirect_addr_o;
  logic                  if_id_hold_o;
  logic                  if_id_flush_o;
  logic                  id_ex_hold_o;
  logic                  id_ex_flush_o;
  logic                  halt_ack_o;
  logic                  halted_o;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]           stall_cnt_o;
  logic [31:0]           flush_cnt_o;

  modport slave (
    input  jump_req_i, jump_addr_i, ld_use_i, md_start_i, md_done_i, halt_req_i, resume_i,
    output pc_hold_o, pc_redirect_o, pc_redirect_addr_o, if_id_hold_o, if_id_flush_o,
    output id_ex_hold_o, id_ex_flush_o, halt_ack_o, halted_o, stall_cnt_o, flush_cnt_o
  );

  modport master (
    output jump_req_i, jump_addr_i, ld_use_i, md_start_i, md_done_i, halt_req_i, resume_i,
    input  pc_hold_o, pc_redirect_o, pc_redirect_addr_o, if_id_hold_o, if_id_flush_o,
    input  id_ex_hold_o, id_ex_flush_o, halt_ack_o, halted_o, stall_cnt_o, flush_cnt_o
  );
`else
  modport slave (
    input  jump_req_i, jump_addr_i, ld_use_i, md_start_i, md_done_i, halt_req_i, resume_i,
    output pc_hold_o, pc_redirect_o, pc_redirect_addr_o, if_id_hold_o, if_id_flush_o,
    output id_ex_hold_o, id_ex_flush_o, halt_ack_o, halted_o
  );

  modport master (
    output jump_req_i, jump_addr_i, ld_use_i, md_start_i, md_done_i, halt_req_i, resume_i,
    input  pc_hold_o, pc_redirect_o, pc_redirect_addr_o, if_id_hold_o, if_id_flush_o,
    input  id_ex_hold_o, id_ex_flush_o, halt_ack_o, halted_o
  );
`endif

endinterface

// File: rtl/pipe_perf_cnt.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module pipe_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_i,
  output logic [31:0] cnt_o
);

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: owns PC / IF/ID / ID/EX hold and flush decisions for
// jumps, load-use, multi-cycle ops and debug halt. Optional counters: PIPE_CTRL_PERF_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = AddrWidthDefault,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  pipe_ctrl_if.slave    bus
);

  localparam int unsigned CntW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CntW-1:0] DrainInit = CntW'(DRAIN_CYCLES - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            md_pending_q, md_pending_d;
  logic            halt_ack_q, halt_ack_d;
  logic            halted_q, halted_d;

  logic pc_hold, pc_redirect, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    md_pending_d = md_pending_q;
    pc_hold      = 1'b0;
    pc_redirect  = 1'b0;
    if_id_hold   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_hold   = 1'b0;
    id_ex_flush  = 1'b0;

    unique case (state_q)
      StRun: begin
        md_pending_d = 1'b0;
        if (bus.jump_req_i) begin
          pc_redirect = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (bus.md_start_i) begin
          // An op that completes in its start cycle needs no stall at all.
          if (!bus.md_done_i) begin
            pc_hold    = 1'b1;
            if_id_hold = 1'b1;
            id_ex_hold = 1'b1;
            state_d    = StMdWait;
          end
        end else if (bus.ld_use_i) begin
          pc_hold     = 1'b1;
          if_id_hold  = 1'b1;
          id_ex_flush = 1'b1;
        end else if (bus.halt_req_i) begin
          pc_hold     = 1'b1;
          if_id_flush = 1'b1;
          cnt_d       = DrainInit;
          state_d     = StDrain;
        end
      end
      StMdWait: begin
        if (bus.md_done_i) begin
          state_d = StRun;
        end else begin
          pc_hold    = 1'b1;
          if_id_hold = 1'b1;
          id_ex_hold = 1'b1;
        end
      end
      StDrain: begin
        pc_hold     = 1'b1;
        if_id_flush = 1'b1;
        if (bus.jump_req_i) begin
          pc_redirect = 1'b1;
          id_ex_flush = 1'b1;
        end
        // A multi-cycle op entering EX while draining freezes the countdown until it completes.
        md_pending_d = !bus.md_done_i && (md_pending_q || bus.md_start_i);
        if (!md_pending_d) begin
          if (cnt_q == '0) begin
            state_d = StHalted;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
      end
      StHalted: begin
        pc_hold     = 1'b1;
        if_id_flush = 1'b1;
        if (bus.resume_i) begin
          state_d = StRun;
        end
      end
    endcase

    halted_d   = (state_d == StHalted);
    halt_ack_d = (state_d == StHalted) && (state_q != StHalted);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StRun;
      cnt_q        <= '0;
      md_pending_q <= 1'b0;
      halt_ack_q   <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      md_pending_q <= md_pending_d;
      halt_ack_q   <= halt_ack_d;
      halted_q     <= halted_d;
    end
  end

  assign bus.pc_hold_o          = pc_hold;
  assign bus.pc_redirect_o      = pc_redirect;
  assign bus.pc_redirect_addr_o = pc_redirect ? bus.jump_addr_i : '0;
  assign bus.if_id_hold_o       = if_id_hold;
  assign bus.if_id_flush_o      = if_id_flush;
  assign bus.id_ex_hold_o       = id_ex_hold;
  assign bus.id_ex_flush_o      = id_ex_flush;
  assign bus.halt_ack_o         = halt_ack_q;
  assign bus.halted_o           = halted_q;

`ifdef PIPE_CTRL_PERF_EN
  logic stall_inc;

  assign stall_inc = pc_hold && ((state_q == StRun) || (state_q == StMdWait));

  pipe_perf_cnt u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (stall_inc),
    .cnt_o (bus.stall_cnt_o)
  );

  pipe_perf_cnt u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (pc_redirect),
    .cnt_o (bus.flush_cnt_o)
  );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: each directed cycle pushes its hand-computed outputs,
// a negedge monitor pops and compares against what the DUT presents.
module tb_pipe_ctrl;

  localparam int unsigned AW = 32;

  // {pc_hold, pc_redirect, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, halt_ack, halted}
  localparam logic [7:0] CtlIdle      = 8'b0000_0000;
  localparam logic [7:0] CtlJump      = 8'b0101_0100;
  localparam logic [7:0] CtlLdUse     = 8'b1010_0100;
  localparam logic [7:0] CtlMdw       = 8'b1010_1000;
  localparam logic [7:0] CtlDrain     = 8'b1001_0000;
  localparam logic [7:0] CtlDrnJump   = 8'b1101_0100;
  localparam logic [7:0] CtlHaltEnter = 8'b1001_0011;
  localparam logic [7:0] CtlHalted    = 8'b1001_0001;

  logic clk;
  logic rst_n;

  pipe_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  pipe_ctrl #(
    .ADDR_WIDTH   (AW),
    .DRAIN_CYCLES (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  string       q_name[$];
  logic [39:0] q_exp[$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  task automatic step(input string name, input logic rst, input logic jr,
                      input logic [AW-1:0] ja, input logic lu, input logic ms,
                      input logic md, input logic hr, input logic rs,
                      input logic [7:0] ctl, input logic [AW-1:0] addr);
    @(posedge clk);
    #1;
    rst_n           = rst;
    bus.jump_req_i  = jr;
    bus.jump_addr_i = ja;
    bus.ld_use_i    = lu;
    bus.md_start_i  = ms;
    bus.md_done_i   = md;
    bus.halt_req_i  = hr;
    bus.resume_i    = rs;
    q_name.push_back(name);
    q_exp.push_back({ctl, addr});
  endtask

  task automatic idle(input string name);
    step(name, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CtlIdle, '0);
  endtask

  always @(negedge clk) begin
    if (q_exp.size() > 0) begin
      string       nm;
      logic [39:0] exp_v;
      logic [39:0] act_v;
      nm    = q_name.pop_front();
      exp_v = q_exp.pop_front();
      act_v = {bus.pc_hold_o, bus.pc_redirect_o, bus.if_id_hold_o, bus.if_id_flush_o,
               bus.id_ex_hold_o, bus.id_ex_flush_o, bus.halt_ack_o, bus.halted_o,
               bus.pc_redirect_addr_o};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL %s: got ctl=%b addr=%h, want ctl=%b addr=%h",
                 nm, act_v[39:32], act_v[31:0], exp_v[39:32], exp_v[31:0]);
      end
    end
  end

  // The stimulus never drives jump/load-use while a multi-cycle op is stalling EX.
  always @(posedge clk) begin
    if (rst_n && bus.id_ex_hold_o) begin
      assert (!(bus.jump_req_i || bus.ld_use_i))
        else $error("illegal jump/ld_use while waiting on multi-cycle op");
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n           = 1'b0;
    bus.jump_req_i  = 1'b0;
    bus.jump_addr_i = '0;
    bus.ld_use_i    = 1'b0;
    bus.md_start_i  = 1'b0;
    bus.md_done_i   = 1'b0;
    bus.halt_req_i  = 1'b0;
    bus.resume_i    = 1'b0;

    step("reset0", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CtlIdle, '0);
    step("reset1", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CtlIdle, '0);
    idle("idle_after_reset");
    idle("idle_after_reset");

    // Jump redirect and flush, same cycle.
    step("jump", 1'b1, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CtlJump, 32'h0000_0100);
    step("jump_next_addr0", 1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CtlIdle, '0);

    // Load-use: one bubble.
    step("ld_use", 1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CtlLdUse, '0);
    idle("ld_use_next");

    // Jump beats md_start, ld_use and halt_req.
    step("prio_jump", 1'b1, 1'b1, 32'hdead_beec, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, CtlJump,
         32'hdead_beec);
    idle("prio_jump_next");

    // Multi-cycle op: start at c, done at c+5 -> holds c..c+4.
    step("md_start", 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, CtlMdw, '0);
    for (int i = 0; i < 4; i++) begin
      step("md_wait", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CtlMdw, '0);
    end
    step("md_done", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, CtlIdle, '0);
    idle("md_after");

    // Start and done together: no stall.
    step("md_both", 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, CtlIdle, '0);
    idle("md_both_next");

    // Load-use beats halt_req; halt not entered.
    step("prio_ld_use", 1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, CtlLdUse, '0);
    idle("prio_ld_use_next");

    // Halt pulse at N: DRAIN N+1..N+3, ack/halted at N+4.
    step("halt_req", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, CtlDrain, '0);
    step("drain1_resume_ign", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, CtlDrain, '0);
    step("drain2_jump", 1'b1, 1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CtlDrnJump,
         32'h0000_0200);
    step("drain3", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CtlDrain, '0);
    step("halt_enter", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CtlHaltEnter, '0);
    step("halted_req_ign", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, CtlHalted, '0);
    step("halted", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CtlHalted, '0);
    step("resume", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, CtlHalted, '0);
    idle("resumed");
    idle("resumed2");

    // md op in first DRAIN cycle, done 4 cycles later: halt delayed by 4 (N+8).
    step("halt_req2", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, CtlDrain, '0);
    step("drain_md_start", 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, CtlDrain, '0);
    for (int i = 0; i < 3; i++) begin
      step("drain_md_pending", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CtlDrain, '0);
    end
    step("drain_md_done", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, CtlDrain, '0);
    step("drain_post_md", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CtlDrain, '0);
    step("drain_post_md", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CtlDrain, '0);
    step("halt_enter2", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CtlHaltEnter, '0);
    step("resume2", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, CtlHalted, '0);
    idle("resumed3");

    // Reset during DRAIN: back to RUN, halt pulse lost.
    step("halt_req3", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, CtlDrain, '0);
    step("drain_pre_rst", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CtlDrain, '0);
    step("rst_in_drain", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CtlIdle, '0);
    idle("rst_release");
    for (int i = 0; i < 4; i++) begin
      idle("post_rst_no_halt");
    end

    repeat (2) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
